thumb_mini_cpu: RTL and testbench

Single-cycle processor for a small subset of the 16-bit ARM Thumb instruction set, with a loadable 256-entry instruction memory and a 32-bit memory-mapped GPIO output register. A board-level wrapper streams a program in through the write port, then releases the core, which drives the LEDs from `gpio_state`. The clock comes from the separate `ClockDivisor` block, which is outside this block's scope.

---
 rtl/thumb_mini_cpu_pkg.sv | 64 ++++++
 rtl/thumb_mini_cpu_alu.sv | 69 ++++++
 rtl/thumb_mini_cpu.sv | 231 +++++++++++++++++++++++
 tb/tb_thumb_mini_cpu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/thumb_mini_cpu_pkg.sv
// Shared definitions for the Thumb-subset core: opcode fields, condition codes,
// flag layout and the memory-mapped GPIO address.
package thumb_mini_cpu_pkg;

   // Major opcode values taken from instruction bits [15:11]
   localparam logic [4:0] OP_LSL_IMM = 5'b00000;
   localparam logic [4:0] OP_LSR_IMM = 5'b00001;
   localparam logic [4:0] OP_ADDSUB  = 5'b00011;
   localparam logic [4:0] OP_MOV_IMM = 5'b00100;
   localparam logic [4:0] OP_CMP_IMM = 5'b00101;
   localparam logic [4:0] OP_ADD_IMM = 5'b00110;
   localparam logic [4:0] OP_SUB_IMM = 5'b00111;
   localparam logic [4:0] OP_STR_IMM = 5'b01100;
   localparam logic [4:0] OP_LDR_IMM = 5'b01101;
   localparam logic [4:0] OP_BCOND_0 = 5'b11010;
   localparam logic [4:0] OP_BCOND_1 = 5'b11011;
   localparam logic [4:0] OP_B       = 5'b11100;

   localparam logic [31:0] GPIO_ADDR = 32'h0000_0020;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
      COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
      COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
      COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14
   } cond_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_LSL = 3'd2,
      ALU_LSR = 3'd3,
      ALU_MOV = 3'd4
   } alu_op_e;

   // Encodings 1110/1111 are not conditional branches, so they never pass
   function automatic logic cond_pass(input logic [3:0] cond, input flags_t f);
      case (cond)
         COND_EQ: cond_pass = f.z;
         COND_NE: cond_pass = !f.z;
         COND_CS: cond_pass = f.c;
         COND_CC: cond_pass = !f.c;
         COND_MI: cond_pass = f.n;
         COND_PL: cond_pass = !f.n;
         COND_VS: cond_pass = f.v;
         COND_VC: cond_pass = !f.v;
         COND_HI: cond_pass = f.c && !f.z;
         COND_LS: cond_pass = !f.c || f.z;
         COND_GE: cond_pass = (f.n == f.v);
         COND_LT: cond_pass = (f.n != f.v);
         COND_GT: cond_pass = !f.z && (f.n == f.v);
         COND_LE: cond_pass = f.z || (f.n != f.v);
         default: cond_pass = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/thumb_mini_cpu_alu.sv
// Combinational add/sub/shift/move unit producing the result and updated NZCV.
module thumb_alu
   import thumb_mini_cpu_pkg::*;
(
   input  alu_op_e     i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [4:0]  i_shamt,
   input  flags_t      i_flags,
   output logic [31:0] o_result,
   output flags_t      o_flags
);

   logic [32:0] w_sum;
   logic [32:0] w_diff;
   logic [32:0] w_shl;
   logic [32:0] w_shr;
   logic [31:0] w_res;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};
   // Extra bit catches the last bit shifted out in either direction
   assign w_shl  = {1'b0, i_a} << i_shamt;
   assign w_shr  = {i_a, 1'b0} >> i_shamt;

   // Result select and flag generation; C and V are preserved unless the op defines them
   always_comb begin
      w_res   = i_a;
      o_flags = i_flags;
      case (i_op)
         ALU_ADD: begin
            w_res     = w_sum[31:0];
            o_flags.c = w_sum[32];
            o_flags.v = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
         end
         ALU_SUB: begin
            w_res     = w_diff[31:0];
            o_flags.c = !w_diff[32];
            o_flags.v = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
         end
         ALU_LSL: begin
            w_res = w_shl[31:0];
            if (i_shamt != 5'd0) begin
               o_flags.c = w_shl[32];
            end else begin
               o_flags.c = i_flags.c;
            end
         end
         ALU_LSR: begin
            w_res = w_shr[32:1];
            if (i_shamt != 5'd0) begin
               o_flags.c = w_shr[0];
            end else begin
               o_flags.c = i_flags.c;
            end
         end
         ALU_MOV: begin
            w_res = i_b;
         end
         default: begin
            w_res = i_a;
         end
      endcase
      o_flags.n = w_res[31];
      o_flags.z = (w_res == 32'd0);
      o_result  = w_res;
   end

endmodule

// File: rtl/thumb_mini_cpu.sv
// Single-cycle Thumb-subset core with a loadable 256-halfword program store,
// a 16-word data RAM and a memory-mapped 32-bit GPIO register.
module thumb_mini_cpu
   import thumb_mini_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        write,
   input  logic [7:0]  write_instruction_index,
   input  logic [15:0] write_instruction,
   output logic [31:0] gpio_state,
   output logic [31:0] index
);

   logic [15:0] r_imem [0:255];
   logic [31:0] r_dram [0:15];
   logic [31:0] r_regs [0:7];
   logic [8:0]  r_pc;
   flags_t      r_flags;
   logic [31:0] r_gpio;

   logic [15:0] w_fetch;
   logic [15:0] w_instr;
   logic [4:0]  w_op5;
   logic [4:0]  w_imm5;
   logic [7:0]  w_imm8;
   logic [2:0]  w_lo_a;
   logic [2:0]  w_lo_b;
   logic [2:0]  w_lo_c;
   logic [2:0]  w_hi;
   logic [3:0]  w_cond;
   logic [29:0] w_waddr;
   logic        w_addr_gpio;
   logic        w_addr_ram;
   logic [31:0] w_ld_data;
   logic [8:0]  w_pc_inc;
   logic [8:0]  w_br_target;

   alu_op_e     w_alu_op;
   logic [31:0] w_alu_a;
   logic [31:0] w_alu_b;
   logic [4:0]  w_alu_sh;
   logic [31:0] w_alu_res;
   flags_t      w_alu_flags;

   logic        w_rf_we;
   logic        w_is_load;
   logic [2:0]  w_rd;
   logic        w_flags_we;
   logic        w_st_gpio;
   logic        w_st_ram;
   logic [8:0]  w_pc_next;
   logic [31:0] w_rf_wdata;

   assign w_fetch = r_imem[r_pc[8:1]];
   assign w_instr = {w_fetch[7:0], w_fetch[15:8]};
   assign w_op5   = w_instr[15:11];
   assign w_imm5  = w_instr[10:6];
   assign w_imm8  = w_instr[7:0];
   assign w_lo_a  = w_instr[2:0];
   assign w_lo_b  = w_instr[5:3];
   assign w_lo_c  = w_instr[8:6];
   assign w_hi    = w_instr[10:8];
   assign w_cond  = w_instr[11:8];

   // Word address of Rn + imm5*4; the byte offset within a word is irrelevant
   assign w_waddr     = r_regs[w_lo_b][31:2] + {25'd0, w_imm5};
   assign w_addr_gpio = (w_waddr == GPIO_ADDR[31:2]);
   assign w_addr_ram  = (w_waddr[29:4] == 26'd0) && !w_addr_gpio;

   assign w_pc_inc = r_pc + 9'd2;
   // With a 9-bit PC only offset bits [7:0] matter, which b and b<cond> share
   assign w_br_target = r_pc + 9'd4 + {w_imm8, 1'b0};

   thumb_alu u_alu (
      .i_op     (w_alu_op),
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .i_shamt  (w_alu_sh),
      .i_flags  (r_flags),
      .o_result (w_alu_res),
      .o_flags  (w_alu_flags)
   );

   // Load data source: GPIO register, data RAM, or zero for unmapped addresses
   always_comb begin
      w_ld_data = 32'd0;
      if (w_addr_gpio) begin
         w_ld_data = r_gpio;
      end else if (w_addr_ram) begin
         w_ld_data = r_dram[w_waddr[3:0]];
      end else begin
         w_ld_data = 32'd0;
      end
   end

   // Instruction decode; unsupported encodings fall through as NOPs
   always_comb begin
      w_alu_op   = ALU_ADD;
      w_alu_a    = 32'd0;
      w_alu_b    = 32'd0;
      w_alu_sh   = 5'd0;
      w_rf_we    = 1'b0;
      w_is_load  = 1'b0;
      w_rd       = w_lo_a;
      w_flags_we = 1'b0;
      w_st_gpio  = 1'b0;
      w_st_ram   = 1'b0;
      w_pc_next  = w_pc_inc;
      case (w_op5)
         OP_LSL_IMM: begin
            w_alu_op = ALU_LSL;
            w_alu_a  = r_regs[w_lo_b];
            w_alu_sh = w_imm5;
            if (w_instr != 16'h0000) begin
               w_rf_we    = 1'b1;
               w_flags_we = 1'b1;
            end else begin
               w_rf_we    = 1'b0;
               w_flags_we = 1'b0;
            end
         end
         OP_LSR_IMM: begin
            w_alu_op   = ALU_LSR;
            w_alu_a    = r_regs[w_lo_b];
            w_alu_sh   = w_imm5;
            w_rf_we    = 1'b1;
            w_flags_we = 1'b1;
         end
         OP_ADDSUB: begin
            w_alu_op = w_instr[9] ? ALU_SUB : ALU_ADD;
            w_alu_a  = r_regs[w_lo_b];
            w_alu_b  = r_regs[w_lo_c];
            if (!w_instr[10]) begin
               w_rf_we    = 1'b1;
               w_flags_we = 1'b1;
            end else begin
               w_rf_we    = 1'b0;
               w_flags_we = 1'b0;
            end
         end
         OP_MOV_IMM: begin
            w_alu_op   = ALU_MOV;
            w_alu_b    = {24'd0, w_imm8};
            w_rd       = w_hi;
            w_rf_we    = 1'b1;
            w_flags_we = 1'b1;
         end
         OP_CMP_IMM: begin
            w_alu_op   = ALU_SUB;
            w_alu_a    = r_regs[w_hi];
            w_alu_b    = {24'd0, w_imm8};
            w_flags_we = 1'b1;
         end
         OP_ADD_IMM, OP_SUB_IMM: begin
            w_alu_op   = (w_op5 == OP_SUB_IMM) ? ALU_SUB : ALU_ADD;
            w_alu_a    = r_regs[w_hi];
            w_alu_b    = {24'd0, w_imm8};
            w_rd       = w_hi;
            w_rf_we    = 1'b1;
            w_flags_we = 1'b1;
         end
         OP_STR_IMM: begin
            w_st_gpio = w_addr_gpio;
            w_st_ram  = w_addr_ram;
         end
         OP_LDR_IMM: begin
            w_rf_we   = 1'b1;
            w_is_load = 1'b1;
         end
         OP_BCOND_0, OP_BCOND_1: begin
            if (cond_pass(w_cond, r_flags)) begin
               w_pc_next = w_br_target;
            end else begin
               w_pc_next = w_pc_inc;
            end
         end
         OP_B: begin
            w_pc_next = w_br_target;
         end
         default: begin
            w_pc_next = w_pc_inc;
         end
      endcase
   end

   assign w_rf_wdata = w_is_load ? w_ld_data : w_alu_res;

   // Architectural state: load mode parks the PC at 0 and freezes everything else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= 9'd0;
         r_flags <= '0;
         r_gpio  <= 32'd0;
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else if (write) begin
         r_pc <= 9'd0;
      end else begin
         r_pc <= w_pc_next;
         if (w_rf_we) begin
            r_regs[w_rd] <= w_rf_wdata;
         end
         if (w_flags_we) begin
            r_flags <= w_alu_flags;
         end
         if (w_st_gpio) begin
            r_gpio <= r_regs[w_lo_a];
         end
      end
   end

   // Program store keeps its contents across reset; loads are blocked while in reset
   always_ff @(posedge clk) begin
      if (rst_n && write) begin
         r_imem[write_instruction_index] <= write_instruction;
      end
   end

   // Data RAM write port
   always_ff @(posedge clk) begin
      if (rst_n && !write && w_st_ram) begin
         r_dram[w_waddr[3:0]] <= r_regs[w_lo_a];
      end
   end

   assign gpio_state = r_gpio;
   assign index      = {23'd0, r_pc};

endmodule

// File: tb/tb_thumb_mini_cpu.sv
// Directed self-checking bench for thumb_mini_cpu: empty-memory PC walk,
// the GPIO shift program, reset mid-run, and a RAM/GPIO load-store program.
module tb_thumb_mini_cpu;

   logic        clk;
   logic        rst_n;
   logic        write;
   logic [7:0]  write_instruction_index;
   logic [15:0] write_instruction;
   logic [31:0] gpio_state;
   logic [31:0] index;

   int errors;
   int checks;

   // Program A as stored in memory (already byte-swapped), slots 10..22
   logic [15:0] prog_a [0:12] = '{16'h2021, 16'h0022, 16'h0023, 16'h082b, 16'hfad0,
                                  16'h5200, 16'h042b, 16'h00da, 16'h0132, 16'h0133,
                                  16'h0a60, 16'hf6e7, 16'hfee7};
   // Program B in natural Thumb encoding, slots 0..15
   logic [15:0] prog_b [0:15] = '{16'h205a, 16'h2104, 16'h2320, 16'h6008, 16'h680a,
                                  16'h601a, 16'h681c, 16'h1824, 16'h08a4, 16'h601c,
                                  16'h1a25, 16'hd200, 16'h601d, 16'h6a1e, 16'h601e,
                                  16'he7fe};
   logic [31:0] exp_gpio [0:7] = '{32'd1, 32'd3, 32'd7, 32'd15, 32'd30, 32'd60,
                                   32'd120, 32'd240};

   thumb_mini_cpu dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .write                   (write),
      .write_instruction_index (write_instruction_index),
      .write_instruction       (write_instruction),
      .gpio_state              (gpio_state),
      .index                   (index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] swap16(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wait_pc(input logic [31:0] target, input int budget);
      int n;
      n = 0;
      while (index !== target && n < budget) begin
         step();
         n++;
      end
      check($sformatf("reach_pc_%0d", target), index, target);
   endtask

   initial begin
      logic [31:0] prev;
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      write = 1'b0;
      write_instruction_index = 8'd0;
      write_instruction = 16'd0;

      #12;
      check("reset_index", index, 32'd0);
      check("reset_gpio", gpio_state, 32'd0);
      step();
      rst_n = 1'b1;

      // Clear the whole program store, then run it as NOPs
      write = 1'b1;
      for (int i = 0; i < 256; i++) begin
         write_instruction_index = i[7:0];
         write_instruction = 16'h0000;
         step();
      end
      write = 1'b0;
      check("load_pc_held", index, 32'd0);
      step();
      check("empty_first", index, 32'd2);
      step();
      check("empty_second", index, 32'd4);
      for (int i = 0; i < 253; i++) step();
      check("empty_510", index, 32'd510);
      step();
      check("empty_wrap", index, 32'd0);
      check("empty_gpio", gpio_state, 32'd0);

      // Load program A while running; core must park at PC 0
      write = 1'b1;
      for (int i = 0; i < 13; i++) begin
         write_instruction_index = 8'(10 + i);
         write_instruction = prog_a[i];
         step();
      end
      write = 1'b0;
      check("progA_loaded_pc", index, 32'd0);
      check("progA_loaded_gpio", gpio_state, 32'd0);

      prev = 32'd0;
      for (int k = 0; k < 8; k++) begin
         wait_pc(32'd34, 60);
         step();
         check($sformatf("bge_next_k%0d", k), index, (k >= 4) ? 32'd38 : 32'd36);
         wait_pc(32'd40, 20);
         check($sformatf("gpio_before_str_k%0d", k), gpio_state, prev);
         step();
         check($sformatf("gpio_seq_k%0d", k), gpio_state, exp_gpio[k]);
         prev = exp_gpio[k];
      end
      wait_pc(32'd28, 20);
      step();
      check("beq_taken", index, 32'd20);
      step();
      check("after_beq", index, 32'd22);
      wait_pc(32'd40, 40);
      step();
      check("gpio_repeat", gpio_state, 32'd1);

      // Asynchronous reset mid-run; a load attempt during reset must be ignored
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_gpio", gpio_state, 32'd0);
      check("async_rst_index", index, 32'd0);
      write = 1'b1;
      write_instruction_index = 8'd10;
      write_instruction = 16'hfee7;
      step();
      write = 1'b0;
      write_instruction = 16'h0000;
      check("rst_wins_index", index, 32'd0);
      rst_n = 1'b1;
      wait_pc(32'd40, 60);
      step();
      check("restart_gpio", gpio_state, 32'd1);

      // Program B: RAM round trip, GPIO readback, reg add, lsrs, subs, bcs, unmapped load
      write = 1'b1;
      for (int i = 0; i < 16; i++) begin
         write_instruction_index = i[7:0];
         write_instruction = swap16(prog_b[i]);
         step();
      end
      write = 1'b0;
      check("progB_loaded_pc", index, 32'd0);
      check("progB_gpio_held", gpio_state, 32'd1);
      step();
      check("progB_first_exec", index, 32'd2);
      wait_pc(32'd10, 20);
      step();
      check("ram_round_trip", gpio_state, 32'h0000_005a);
      wait_pc(32'd18, 20);
      step();
      check("gpio_ldr_add_lsr", gpio_state, 32'h0000_002d);
      wait_pc(32'd24, 20);
      step();
      check("subs_result", gpio_state, 32'hffff_ffd3);
      wait_pc(32'd28, 20);
      step();
      check("unmapped_ldr", gpio_state, 32'd0);
      wait_pc(32'd30, 20);
      step();
      check("self_loop_1", index, 32'd30);
      step();
      step();
      check("self_loop_3", index, 32'd30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
